// File: rtl/keypoint_merge.sv
// Merges two raster-ordered keypoint SRAM lists into one valid/ready stream.
// A location found in both lists is emitted once, tagged scale 11.
module keypoint_merge #(
    parameter int KP_DEPTH = 2048,
    parameter int AW       = 11
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [11:0]   i_kp1_count,
    input  logic [11:0]   i_kp2_count,
    output logic [AW-1:0] o_kp1_addr,
    input  logic [18:0]   i_kp1_dout,
    output logic [AW-1:0] o_kp2_addr,
    input  logic [18:0]   i_kp2_dout,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [8:0]    o_out_row,
    output logic [9:0]    o_out_col,
    output logic [1:0]    o_out_scale,
    output logic          o_busy,
    output logic          o_done,
    output logic [11:0]   o_dup_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [11:0] DEPTH = 12'(KP_DEPTH);

    state_t      r_state;
    logic [11:0] r_c1, r_c2;
    logic [11:0] r_i1, r_i2;
    logic [11:0] r_dup;
    logic [18:0] r_h1, r_h2;
    logic        r_v1, r_v2;
    logic        r_f1, r_f2;

    logic        w_take1, w_take2, w_valid;
    logic [18:0] w_key;

    // Equal keys make both takes true, which is exactly the scale-11 case.
    always_comb begin
        w_take1 = r_v1 && (!r_v2 || (r_h1 <= r_h2));
        w_take2 = r_v2 && (!r_v1 || (r_h2 <= r_h1));
        w_valid = (r_state == ST_EMIT) && (r_v1 || r_v2);
        w_key   = w_take1 ? r_h1 : r_h2;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_c1    <= '0;
            r_c2    <= '0;
            r_i1    <= '0;
            r_i2    <= '0;
            r_dup   <= '0;
            r_h1    <= '0;
            r_h2    <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_f1    <= 1'b0;
            r_f2    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_c1    <= (i_kp1_count > DEPTH) ? DEPTH : i_kp1_count;
                        r_c2    <= (i_kp2_count > DEPTH) ? DEPTH : i_kp2_count;
                        r_i1    <= '0;
                        r_i2    <= '0;
                        r_dup   <= '0;
                        r_f1    <= 1'b1;
                        r_f2    <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    if (r_f1) begin
                        r_v1 <= (r_i1 < r_c1);
                        if (r_i1 < r_c1) r_h1 <= i_kp1_dout;
                    end
                    if (r_f2) begin
                        r_v2 <= (r_i2 < r_c2);
                        if (r_i2 < r_c2) r_h2 <= i_kp2_dout;
                    end
                    r_f1    <= 1'b0;
                    r_f2    <= 1'b0;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (!r_v1 && !r_v2) begin
                        r_state <= ST_DONE;
                    end else if (i_out_ready) begin
                        r_i1    <= r_i1 + {11'd0, w_take1};
                        r_i2    <= r_i2 + {11'd0, w_take2};
                        r_f1    <= w_take1;
                        r_f2    <= w_take2;
                        if (w_take1 && w_take2) r_dup <= r_dup + 12'd1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_out_valid = w_valid;
        o_out_row   = w_valid ? w_key[18:10] : '0;
        o_out_col   = w_valid ? w_key[9:0]   : '0;
        o_out_scale = w_valid ? {w_take2, w_take1} : 2'b00;
        o_kp1_addr  = r_i1[AW-1:0];
        o_kp2_addr  = r_i2[AW-1:0];
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_DONE);
        o_dup_count = r_dup;
    end

endmodule

// File: tb/tb_keypoint_merge.sv
// Randomized bench for keypoint_merge: SRAM models, a list-merge reference
// model and a per-cycle compare process on the output stream.
module tb_keypoint_merge;

    localparam int KP = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] kp1_count = '0, kp2_count = '0;
    logic [10:0] kp1_addr, kp2_addr;
    logic [18:0] kp1_dout = '0, kp2_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_row;
    logic [9:0]  out_col;
    logic [1:0]  out_scale;
    logic        busy, done;
    logic [11:0] dup_count;

    always #5 clk = ~clk;

    keypoint_merge #(.KP_DEPTH(KP), .AW(11)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_kp1_count(kp1_count), .i_kp2_count(kp2_count),
        .o_kp1_addr(kp1_addr), .i_kp1_dout(kp1_dout),
        .o_kp2_addr(kp2_addr), .i_kp2_dout(kp2_dout),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_row(out_row), .o_out_col(out_col), .o_out_scale(out_scale),
        .o_busy(busy), .o_done(done), .o_dup_count(dup_count)
    );

    logic [18:0] mem1 [KP];
    logic [18:0] mem2 [KP];

    always @(posedge clk) begin
        kp1_dout <= mem1[kp1_addr];
        kp2_dout <= mem2[kp2_addr];
    end

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rdy_mode = 0;   // 0 hold high, 1 random, 2 hold low
    bit mon_en = 1'b0;

    logic [20:0] exp_q[$];
    int          exp_dup;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: ordered merge of the first n1/n2 entries, equal keys fused.
    task automatic build_model(input int n1, input int n2);
        int a = 0;
        int b = 0;
        exp_q.delete();
        exp_dup = 0;
        while (a < n1 || b < n2) begin
            if (b >= n2 || (a < n1 && mem1[a] < mem2[b])) begin
                exp_q.push_back({mem1[a], 2'b01}); a++;
            end else if (a >= n1 || mem2[b] < mem1[a]) begin
                exp_q.push_back({mem2[b], 2'b10}); b++;
            end else begin
                exp_q.push_back({mem1[a], 2'b11}); a++; b++; exp_dup++;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [20:0] prev_pay;
    logic [21:0] prev_addr;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_payload", {11'd0, out_row, out_col, out_scale}, {11'd0, prev_pay});
                chk("stall_addr", {10'd0, kp1_addr, kp2_addr}, {10'd0, prev_addr});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", {11'd0, out_row, out_col, out_scale}, 32'd0 - 1);
                end else begin
                    chk("out_payload", {11'd0, out_row, out_col, out_scale}, {11'd0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_pay   = {out_row, out_col, out_scale};
            prev_addr  = {kp1_addr, kp2_addr};
        end
    end

    task automatic start_merge(input int cnt1, input int cnt2);
        build_model((cnt1 > KP) ? KP : cnt1, (cnt2 > KP) ? KP : cnt2);
        done_cnt  = 0;
        kp1_count = 12'(cnt1);
        kp2_count = 12'(cnt2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_merge(input string nm);
        int budget;
        budget = 8 * exp_q.size() + 40;
        for (int k = 0; k < budget && done_cnt == 0; k++) @(posedge clk);
        chk({nm, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_leftover"}, exp_q.size(), 32'd0);
        chk({nm, "_dup_count"}, {20'd0, dup_count}, exp_dup);
        chk({nm, "_done_pulses"}, done_cnt, 32'd1);
        chk({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid(input string nm);
        int k;
        for (k = 0; k < 50 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic load_test2();
        mem1[0] = {9'd1, 10'd5};
        mem1[1] = {9'd3, 10'd2};
        mem2[0] = {9'd2, 10'd0};
    endtask

    initial begin
        int n1, n2, key, r, len;
        for (int k = 0; k < KP; k++) begin
            mem1[k] = '0;
            mem2[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dup", {20'd0, dup_count}, 32'd0);
        chk("rst_addr", {10'd0, kp1_addr, kp2_addr}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Empty lists: done exactly in the 4th cycle after start.
        start_merge(0, 0);
        chk("t1_done_e0", {31'd0, done}, 32'd0);
        @(posedge clk); #1; chk("t1_done_e1", {31'd0, done}, 32'd0);
        @(posedge clk); #1; chk("t1_done_e2", {31'd0, done}, 32'd0);
        chk("t1_no_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1; chk("t1_done_e3", {31'd0, done}, 32'd1);
        @(posedge clk); #1; chk("t1_done_e4", {31'd0, done}, 32'd0);
        finish_merge("t1");

        // Small interleave with hand-pinned expectations.
        load_test2();
        start_merge(2, 1);
        chk("t2_model0", {11'd0, exp_q[0]}, {11'd0, 9'd1, 10'd5, 2'b01});
        chk("t2_model1", {11'd0, exp_q[1]}, {11'd0, 9'd2, 10'd0, 2'b10});
        chk("t2_model2", {11'd0, exp_q[2]}, {11'd0, 9'd3, 10'd2, 2'b01});
        chk("t2_model_dup", exp_dup, 32'd0);
        @(posedge clk); #1; chk("t2_valid_e1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1; chk("t2_valid_e2", {31'd0, out_valid}, 32'd1);
        finish_merge("t2");

        // Shared location fused into scale 11.
        mem1[0] = {9'd4, 10'd4};
        mem2[0] = {9'd4, 10'd4};
        mem2[1] = {9'd4, 10'd9};
        start_merge(1, 2);
        chk("t3_model0", {11'd0, exp_q[0]}, {11'd0, 9'd4, 10'd4, 2'b11});
        chk("t3_model1", {11'd0, exp_q[1]}, {11'd0, 9'd4, 10'd9, 2'b10});
        chk("t3_model_dup", exp_dup, 32'd1);
        finish_merge("t3");

        // Back-pressure on the first keypoint.
        load_test2();
        rdy_mode = 2;
        @(posedge clk); #1;
        start_merge(2, 1);
        wait_valid("t4");
        repeat (5) begin @(posedge clk); #1; end
        chk("t4_hold_addr", {21'd0, kp1_addr}, 32'd0);
        chk("t4_hold_payload", {11'd0, out_row, out_col, out_scale}, {11'd0, 9'd1, 10'd5, 2'b01});
        rdy_mode = 0;
        finish_merge("t4");

        // Reset in the middle of emission, then a clean rerun.
        load_test2();
        start_merge(2, 1);
        wait_valid("t5");
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_addr", {10'd0, kp1_addr, kp2_addr}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;
        rdy_mode = 1;
        start_merge(2, 1);
        finish_merge("t5_rerun");

        // Random raster lists with random back-pressure.
        for (int t = 0; t < 12; t++) begin
            n1 = 0; n2 = 0;
            key = $urandom_range(0, 20);
            len = $urandom_range(0, 40);
            for (int k = 0; k < len; k++) begin
                key += $urandom_range(1, 40);
                r = $urandom_range(0, 2);
                if (r != 1) begin mem1[n1] = key[18:0]; n1++; end
                if (r != 0) begin mem2[n2] = key[18:0]; n2++; end
            end
            rdy_mode = (t % 3 == 0) ? 0 : 1;
            start_merge(n1, n2);
            finish_merge("rand");
        end

        // Saturated counts with identical full lists.
        for (int k = 0; k < KP; k++) begin
            mem1[k] = 19'(k * 7 + 3);
            mem2[k] = 19'(k * 7 + 3);
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        start_merge(3000, 3000);
        chk("t6_model_len", exp_q.size(), 32'd2048);
        chk("t6_model_dup", exp_dup, 32'd2048);
        finish_merge("t6");
        chk("t6_dup_literal", {20'd0, dup_count}, 32'd2048);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
